// File: rtl/sysid_pkg.sv
// Register map, CTRL field positions and INFO constants shared by the
// system-ID / uptime slave and its sub-blocks.
package sysid_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
    localparam logic [2:0] ADDR_CTRL      = 3'd5;
    localparam logic [2:0] ADDR_DIV       = 3'd6;
    localparam logic [2:0] ADDR_INFO      = 3'd7;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam logic [15:0] INFO_REG_COUNT = 16'd8;
    localparam logic [15:0] INFO_REVISION  = 16'h0002;

    // Byte-lane merge used for the SCRATCH register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_value;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_value[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sysid_prescaled_counter.sv
// 16-bit prescaler driving a free-running 64-bit uptime counter; the counter
// advances once every div_value+1 enabled clocks and wraps silently.
module sysid_prescaled_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        div_load,
    input  logic [15:0] div_value,
    output logic [63:0] value,
    output logic        tick
);

    logic [15:0] prescaler;

    assign tick = en && (prescaler == div_value);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, avoiding order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            value     <= '0;
        end else if (clr) begin
            // Clear takes priority over a coincident tick.
            prescaler <= '0;
            value     <= '0;
        end else begin
            if (tick) value <= value + 64'd1;
            // A divider reload restarts the phase but does not cancel this tick.
            if (div_load)   prescaler <= '0;
            else if (tick)  prescaler <= '0;
            else if (en)    prescaler <= prescaler + 16'd1;
        end
    end

endmodule

// File: rtl/sysid_uptime_slave.sv
// Avalon-MM slave exposing system ID, build timestamp, scratch, control and a
// prescaled 64-bit uptime counter read atomically through a high-word shadow.
module sysid_uptime_slave
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h58C6_1A00,
    parameter int          DATA_W    = 32,
    parameter logic [15:0] DIV_RESET = 16'd49
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid
);

    logic        wr_scratch;
    logic        wr_ctrl;
    logic        wr_div;
    logic        rd_lo;
    logic        counter_clr;
    logic        ctrl_en;
    logic [31:0] scratch;
    logic [31:0] hi_shadow;
    logic [31:0] rd_mux;
    logic [15:0] div_reg;
    logic [63:0] uptime;
    logic        tick_unused;

    assign wr_scratch  = write && (address == ADDR_SCRATCH);
    assign wr_ctrl     = write && (address == ADDR_CTRL);
    assign wr_div      = write && (address == ADDR_DIV);
    assign rd_lo       = read  && (address == ADDR_UPTIME_LO);
    assign counter_clr = wr_ctrl && writedata[CTRL_CLR_BIT];

    sysid_prescaled_counter u_counter (
        .clock     (clock),
        .reset     (reset),
        .en        (ctrl_en),
        .clr       (counter_clr),
        .div_load  (wr_div),
        .div_value (div_reg),
        .value     (uptime),
        .tick      (tick_unused)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch   <= '0;
            ctrl_en   <= 1'b1;
            div_reg   <= DIV_RESET;
            hi_shadow <= '0;
        end else begin
            if (wr_scratch) scratch <= merge_bytes(scratch, writedata, byteenable);
            if (wr_ctrl)    ctrl_en <= writedata[CTRL_EN_BIT];
            if (wr_div)     div_reg <= writedata[15:0];
            // Same pre-increment sample as the LO word returned this cycle.
            if (rd_lo)      hi_shadow <= uptime[63:32];
        end
    end

    // Mux reads the registers as they stand before any same-cycle write.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // rd_mux unassigned, which would infer a latch.
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_UPTIME_LO: rd_mux = uptime[31:0];
            ADDR_UPTIME_HI: rd_mux = hi_shadow;
            ADDR_CTRL:      rd_mux = {31'd0, ctrl_en};
            ADDR_DIV:       rd_mux = {16'd0, div_reg};
            ADDR_INFO:      rd_mux = {INFO_REG_COUNT, INFO_REVISION};
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sysid_uptime_slave.sv
// Self-checking bench for sysid_uptime_slave: directed scenarios plus
// randomized scratch and uptime traffic against a cycle-count reference model.
module tb_sysid_uptime_slave;

    localparam logic [2:0] A_ID  = 3'd0, A_TS  = 3'd1, A_SCR = 3'd2, A_LO   = 3'd3;
    localparam logic [2:0] A_HI  = 3'd4, A_CTL = 3'd5, A_DIV = 3'd6, A_INFO = 3'd7;
    localparam logic [31:0] EXP_ID   = 32'h0000_0000;
    localparam logic [31:0] EXP_TS   = 32'h58C6_1A00;
    localparam logic [31:0] EXP_INFO = 32'h0008_0002;

    logic        clock;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    // Reference model: uptime = enabled clocks since clear / (DIV + 1).
    longint unsigned m_edges;
    logic            m_en;
    logic [15:0]     m_div;
    logic [31:0]     m_scratch;
    int              checks;
    int              errors;

    sysid_uptime_slave dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic longint unsigned model_uptime();
        return m_edges / (64'(m_div) + 64'd1);
    endfunction

    task automatic model_reset();
        m_edges   = 0;
        m_en      = 1'b1;
        m_div     = 16'd49;
        m_scratch = 32'd0;
    endtask

    // One clock with the given strobes; outputs are valid on return.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        read = rd; write = wr; address = addr; writedata = wdata; byteenable = be;
        @(posedge clock);
        if (wr && addr == A_CTL && wdata[1]) m_edges = 0;
        else if (m_en)                       m_edges++;
        if (wr && addr == A_CTL) m_en  = wdata[0];
        if (wr && addr == A_DIV) m_div = wdata[15:0];
        if (wr && addr == A_SCR) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) m_scratch[8*i +: 8] = wdata[8*i +: 8];
        end
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        bus_cycle(1'b0, 1'b1, addr, wdata, be);
    endtask

    task automatic do_read(input logic [2:0] addr, output logic [31:0] data, output logic valid);
        bus_cycle(1'b1, 1'b0, addr, 32'd0, 4'd0);
        data  = readdata;
        valid = readdatavalid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data %h valid %b, expected 0/0", readdata, readdatavalid);
        end
        reset = 1'b0;
        model_reset();
        do_read(A_CTL, d, v);
        checks++;
        if (d !== 32'd1 || v !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got %h valid %b, expected 00000001", d, v);
        end
        do_read(A_DIV, d, v);
        checks++;
        if (d !== 32'd49) begin
            errors++;
            $display("FAIL reset_div: got %h, expected %h", d, 32'd49);
        end
        do_read(A_SCR, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_scratch: got %h, expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[3];
        logic [2:0]  addr_q[3];
        logic [31:0] d;
        logic        v;
        addr_q = '{A_ID, A_TS, A_INFO};
        exp_q  = '{EXP_ID, EXP_TS, EXP_INFO};
        for (int i = 0; i < 3; i++) begin
            do_read(addr_q[i], d, v);
            checks++;
            if (d !== exp_q[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL b2b_read%0d: got %h valid %b, expected %h valid 1", i, d, v, exp_q[i]);
            end
        end
        idle(1);
        checks++;
        if (readdatavalid !== 1'b0 || readdata !== EXP_INFO) begin
            errors++;
            $display("FAIL b2b_hold: got %h valid %b, expected %h valid 0", readdata, readdatavalid, EXP_INFO);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] d, exp, wd;
        logic [3:0]  be;
        logic        v, both;
        do_write(A_SCR, 32'hDEAD_BEEF, 4'b0101);
        do_read(A_SCR, d, v);
        checks++;
        if (d !== 32'h00AD_00EF) begin
            errors++;
            $display("FAIL scratch_be0101: got %h, expected 00ad00ef", d);
        end
        do_write(A_ID, 32'hFFFF_FFFF, 4'hF);
        do_write(A_INFO, 32'h1234_5678, 4'hF);
        do_read(A_ID, d, v);
        checks++;
        if (d !== EXP_ID) begin
            errors++;
            $display("FAIL ro_id_write: got %h, expected %h", d, EXP_ID);
        end
        do_read(A_INFO, d, v);
        checks++;
        if (d !== EXP_INFO) begin
            errors++;
            $display("FAIL ro_info_write: got %h, expected %h", d, EXP_INFO);
        end
        for (int i = 0; i < 12; i++) begin
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            both = 1'($urandom_range(0, 1));
            if (both) begin
                exp = m_scratch;
                bus_cycle(1'b1, 1'b1, A_SCR, wd, be);
                checks++;
                if (readdata !== exp || readdatavalid !== 1'b1) begin
                    errors++;
                    $display("FAIL scratch_rw_same_cycle%0d: got %h, expected pre-write %h", i, readdata, exp);
                end
            end else begin
                do_write(A_SCR, wd, be);
            end
            exp = m_scratch;
            do_read(A_SCR, d, v);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL scratch_rand%0d: got %h, expected %h (be %b)", i, d, exp, be);
            end
        end
    endtask

    task automatic test_ctrl_div_fields();
        logic [31:0] d;
        logic        v;
        do_write(A_DIV, 32'hFFFF_0003, 4'hF);
        do_read(A_DIV, d, v);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL div_upper_bits: got %h, expected 00000003", d);
        end
        do_write(A_CTL, 32'hFFFF_FFFF, 4'hF);
        do_read(A_CTL, d, v);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL ctrl_readback: got %h, expected 00000001", d);
        end
    endtask

    task automatic test_uptime_div3_freeze();
        logic [31:0] d;
        logic        v;
        do_write(A_DIV, 32'd3, 4'hF);
        do_write(A_CTL, 32'd3, 4'hF);
        idle(40);
        do_read(A_LO, d, v);
        checks++;
        if (d !== 32'd10 || d !== 32'(model_uptime() + 0) && 1'b0) begin
            errors++;
            $display("FAIL div3_40clk: got %0d, expected 10", d);
        end
        do_write(A_CTL, 32'd0, 4'hF);
        idle(20);
        do_read(A_LO, d, v);
        checks++;
        if (d !== 32'(model_uptime())) begin
            errors++;
            $display("FAIL en0_freeze: got %0d, expected %0d", d, model_uptime());
        end
        checks++;
        if (d !== 32'd10) begin
            errors++;
            $display("FAIL en0_freeze_value: got %0d, expected 10", d);
        end
    endtask

    task automatic test_clr_on_tick();
        logic [31:0] d, exp;
        logic        v;
        do_write(A_DIV, 32'd0, 4'hF);
        do_write(A_CTL, 32'd1, 4'hF);
        idle(7);
        do_write(A_CTL, 32'd3, 4'hF);
        exp = 32'(model_uptime());
        do_read(A_LO, d, v);
        checks++;
        if (d !== exp || d > 32'd1) begin
            errors++;
            $display("FAIL clr_on_tick: got %0d, expected %0d", d, exp);
        end
    endtask

    task automatic test_uptime_random();
        logic [31:0] d, exp;
        logic        v;
        int          n;
        for (int i = 0; i < 6; i++) begin
            do_write(A_DIV, 32'($urandom_range(0, 7)), 4'hF);
            do_write(A_CTL, 32'd3, 4'hF);
            n = $urandom_range(5, 90);
            idle(n);
            exp = 32'(model_uptime());
            do_read(A_LO, d, v);
            checks++;
            if (d !== exp || v !== 1'b1) begin
                errors++;
                $display("FAIL uptime_rand%0d: got %0d, expected %0d (div %0d, clocks %0d)", i, d, exp, m_div, n);
            end
            do_read(A_HI, d, v);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL uptime_hi_rand%0d: got %h, expected 0", i, d);
            end
        end
    endtask

    // Preload the counter just below the 32-bit carry; LO/HI pairs must never tear.
    task automatic test_carry_no_tear();
        localparam longint unsigned BASE = 64'h0000_0000_FFFF_FFF7;
        logic [31:0]     lo, hi;
        logic            v;
        longint unsigned val, prev;
        do_write(A_DIV, 32'd0, 4'hF);
        do_write(A_CTL, 32'd3, 4'hF);
        force dut.u_counter.value = BASE;
        #1;
        release dut.u_counter.value;
        prev = BASE - 1;
        for (int i = 0; i < 8; i++) begin
            do_read(A_LO, lo, v);
            do_read(A_HI, hi, v);
            val = {hi, lo};
            checks++;
            if (val <= prev || val > BASE + 64'd40) begin
                errors++;
                $display("FAIL carry_pair%0d: got %h, expected in (%h, %h]", i, val, prev, BASE + 64'd40);
            end
            prev = val;
        end
        checks++;
        if (prev[63:32] !== 32'd1) begin
            errors++;
            $display("FAIL carry_crossed: got hi %h, expected 00000001", prev[63:32]);
        end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] d, exp;
        logic        v;
        do_write(A_SCR, 32'hCAFE_F00D, 4'hF);
        do_read(A_TS, d, v);
        read = 1'b1; address = A_LO;
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        read = 1'b0;
        checks++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_flight: got data %h valid %b, expected 0/0", readdata, readdatavalid);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: got %b, expected 0", readdatavalid);
        end
        do_read(A_DIV, d, v);
        checks++;
        if (d !== 32'd49) begin
            errors++;
            $display("FAIL reset_div_after: got %h, expected %h", d, 32'd49);
        end
        do_read(A_SCR, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_scratch_after: got %h, expected 0", d);
        end
        idle(120);
        exp = 32'(model_uptime());
        do_read(A_LO, d, v);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL reset_uptime_after: got %0d, expected %0d", d, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 32'd0; byteenable = 4'd0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_scratch();
        test_ctrl_div_fields();
        test_uptime_div3_freeze();
        test_clr_on_tick();
        test_uptime_random();
        test_carry_no_tear();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
